mc_ctrl_fsm: RTL and testbench

Parametrised successor to the multi-cycle CPU control unit. It sequences IF/ID/EXE/MEM/WB for the same ISA and drives the same datapath selects. It adds ready/valid handshakes to instruction and data memory, bounded wait-state timeouts, an explicit HALT state, and an explicit FAULT state with cause code. It sits between IR/flags and the datapath; memories may now take more than one cycle.

---
 rtl/mc_ctrl_fsm.sv | 217 +++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle CPU control FSM with memory handshakes, timeouts, HALT/FAULT
// Optional retired-instruction counter enabled by defining MC_PERF_CNT_EN.
module mc_ctrl_fsm #(
    parameter int OP_W        = 6,
    parameter int TMO_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    input  logic            sign,
    input  logic            imem_ready,
    input  logic            dmem_ready,
    output logic            imem_req,
    output logic            PCWre,
    output logic            IRWre,
    output logic            RegWre,
    output logic            mRD,
    output logic            mWR,
    output logic            ALUSrcA,
    output logic            ALUSrcB,
    output logic            DBDataSrc,
    output logic            WrRegDSrc,
    output logic            ExtSel,
    output logic [1:0]      PCSrc,
    output logic [1:0]      RegDst,
    output logic [2:0]      ALUOp,
    output logic            halted,
    output logic            fault,
    output logic [1:0]      fault_code,
    output logic [3:0]      state_dbg,
    output logic [31:0]     instret
);
    localparam logic [3:0] S_IF = 4'd0, S_ID = 4'd1, S_EXE_M = 4'd2, S_MEM = 4'd3, S_WB_L = 4'd4;
    localparam logic [3:0] S_EXE_B = 4'd5, S_EXE_A = 4'd6, S_WB_A = 4'd7, S_HALT = 4'd8, S_FAULT = 4'd9;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    logic [3:0]       state_q, state_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fcode_q, fcode_d;

    logic [5:0]      op6;
    logic [OP_W-1:0] op_hi;
    logic            hi_ok, is_lw, is_sw, is_br, is_jmp, is_jal, is_halt, is_alu;
    logic            tmo_hit, taken;
    logic            req_c, pcw_c, irw_c, regw_c, mrd_c, mwr_c;
    logic [9:0]      sel;

    assign op6   = opcode[5:0];
    assign op_hi = opcode >> 6;
    assign hi_ok = (op_hi == '0);

    always_comb begin
        is_lw   = hi_ok && (op6 == 6'b110001);
        is_sw   = hi_ok && (op6 == 6'b110000);
        is_br   = hi_ok && (op6 == 6'b110100 || op6 == 6'b110101 || op6 == 6'b110110);
        is_jmp  = hi_ok && (op6 == 6'b111000 || op6 == 6'b111001);
        is_jal  = hi_ok && (op6 == 6'b111010);
        is_halt = hi_ok && (op6 == 6'b111111);
        is_alu  = 1'b0;
        if (hi_ok) begin
            case (op6)
                6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                6'b010010, 6'b010011, 6'b011000, 6'b100110, 6'b100111: is_alu = 1'b1;
                default: is_alu = 1'b0;
            endcase
        end
    end

    // {ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc, ExtSel, RegDst, ALUOp}
    always_comb begin
        case (op6)
            6'b000000: sel = 10'b0_0_0_1_0_10_000;
            6'b000001: sel = 10'b0_0_0_1_0_10_001;
            6'b010000: sel = 10'b0_0_0_1_0_10_100;
            6'b100111: sel = 10'b0_0_0_1_0_10_110;
            6'b000010: sel = 10'b0_1_0_1_1_01_000;
            6'b100110: sel = 10'b0_1_0_1_1_01_110;
            6'b010001: sel = 10'b0_1_0_1_0_01_100;
            6'b010010: sel = 10'b0_1_0_1_0_01_011;
            6'b010011: sel = 10'b0_1_0_1_0_01_111;
            6'b011000: sel = 10'b1_0_0_1_0_10_010;
            6'b110000: sel = 10'b0_1_0_1_1_00_000;
            6'b110001: sel = 10'b0_1_1_1_1_01_000;
            6'b110100, 6'b110101: sel = 10'b0_0_0_1_1_00_001;
            6'b110110: sel = 10'b0_0_0_1_1_00_000;
            6'b111000, 6'b111001, 6'b111111: sel = 10'b0_0_0_1_0_00_000;
            default:   sel = 10'b0_0_0_0_0_00_000;
        endcase
    end
    assign {ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc, ExtSel, RegDst, ALUOp} = sel;

    always_comb begin
        case (op6)
            6'b110100: taken = zero;
            6'b110101: taken = !zero;
            6'b110110: taken = sign;
            default:   taken = 1'b0;
        endcase
        if (is_jal || (hi_ok && op6 == 6'b111000)) PCSrc = 2'b11;
        else if (hi_ok && op6 == 6'b111001)        PCSrc = 2'b10;
        else if (is_br && taken)                   PCSrc = 2'b01;
        else                                       PCSrc = 2'b00;
    end

    assign tmo_hit = (MEM_TIMEOUT != 0) && (cnt_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        fcode_d = fcode_q;
        req_c   = 1'b0;
        pcw_c   = 1'b0;
        irw_c   = 1'b0;
        regw_c  = 1'b0;
        mrd_c   = 1'b0;
        mwr_c   = 1'b0;
        case (state_q)
            S_IF: begin
                if (imem_ready) begin
                    req_c   = 1'b1;
                    irw_c   = 1'b1;
                    state_d = S_ID;
                end else if (tmo_hit) begin
                    state_d = S_FAULT;
                    fcode_d = 2'b01;
                end else begin
                    req_c = 1'b1;
                end
            end
            S_ID: begin
                if (is_br)         state_d = S_EXE_B;
                else if (is_lw || is_sw) state_d = S_EXE_M;
                else if (is_jmp || is_jal) begin
                    pcw_c   = 1'b1;
                    regw_c  = is_jal;
                    state_d = S_IF;
                end
                else if (is_halt)  state_d = S_HALT;
                else if (is_alu)   state_d = S_EXE_A;
                else begin
                    state_d = S_FAULT;
                    fcode_d = 2'b10;
                end
            end
            S_EXE_A: state_d = S_WB_A;
            S_EXE_M: state_d = S_MEM;
            S_EXE_B: begin
                pcw_c   = 1'b1;
                state_d = S_IF;
            end
            S_WB_A, S_WB_L: begin
                regw_c  = 1'b1;
                pcw_c   = 1'b1;
                state_d = S_IF;
            end
            S_MEM: begin
                if (dmem_ready) begin
                    mrd_c = is_lw;
                    mwr_c = is_sw;
                    if (is_lw) state_d = S_WB_L;
                    else begin
                        pcw_c   = 1'b1;
                        state_d = S_IF;
                    end
                end else if (tmo_hit) begin
                    state_d = S_FAULT;
                    fcode_d = 2'b01;
                end else begin
                    mrd_c = is_lw;
                    mwr_c = is_sw;
                end
            end
            S_HALT, S_FAULT: state_d = state_q;
            default: state_d = S_IF;
        endcase
    end

    // The counter only runs while parked in IF/MEM; every exit (ready, timeout) clears it.
    assign cnt_d = ((state_q == S_IF || state_q == S_MEM) && state_d == state_q) ? cnt_q + TMO_ONE : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IF;
            cnt_q   <= '0;
            fcode_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fcode_q <= fcode_d;
        end
    end

    // Gate with reset so an in-flight write strobe falls the moment reset asserts.
    assign imem_req   = req_c  & rst;
    assign PCWre      = pcw_c  & rst;
    assign IRWre      = irw_c  & rst;
    assign RegWre     = regw_c & rst;
    assign mRD        = mrd_c  & rst;
    assign mWR        = mwr_c  & rst;
    assign halted     = (state_q == S_HALT);
    assign fault      = (state_q == S_FAULT);
    assign fault_code = fcode_q;
    assign state_dbg  = state_q;

`ifdef MC_PERF_CNT_EN
    logic [31:0] instret_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       instret_q <= '0;
        else if (PCWre) instret_q <= instret_q + 32'd1;
    end
    assign instret = instret_q;
`else
    assign instret = '0;
`endif
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - self-checking bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;
    logic        clk, rst, zero, sign, imem_ready, dmem_ready;
    logic [5:0]  opcode;
    logic        imem_req, PCWre, IRWre, RegWre, mRD, mWR;
    logic        ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc, ExtSel;
    logic [1:0]  PCSrc, RegDst, fault_code;
    logic [2:0]  ALUOp;
    logic        halted, fault;
    logic [3:0]  state_dbg;
    logic [31:0] instret;

    int total = 0;
    int bad   = 0;

    mc_ctrl_fsm dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .sign(sign),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
        .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .mRD(mRD), .mWR(mWR),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .DBDataSrc(DBDataSrc),
        .WrRegDSrc(WrRegDSrc), .ExtSel(ExtSel), .PCSrc(PCSrc), .RegDst(RegDst),
        .ALUOp(ALUOp), .halted(halted), .fault(fault), .fault_code(fault_code),
        .state_dbg(state_dbg), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic       z;
        logic       s;
        logic [9:0] sel;
        logic [1:0] pc;
    } vec_t;
    vec_t tbl[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [5:0] op, input logic ir, input logic dr);
        rst = 1'b0;
        opcode = op;
        imem_ready = ir;
        dmem_ready = dr;
        zero = 1'b0;
        sign = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_instr(input logic [5:0] op, input int n);
        opcode = op;
        repeat (n) tick();
    endtask

    logic [9:0]  sel_now;
    logic [31:0] exp_instret;
    int irw_n, mrd_n, req_n, any_strobe;
    assign sel_now = {ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc, ExtSel, RegDst, ALUOp};

    initial begin
        tbl[0]  = '{6'b000000, 0, 0, 10'b0001010000, 2'b00};
        tbl[1]  = '{6'b000001, 0, 0, 10'b0001010001, 2'b00};
        tbl[2]  = '{6'b010000, 0, 0, 10'b0001010100, 2'b00};
        tbl[3]  = '{6'b100111, 0, 0, 10'b0001010110, 2'b00};
        tbl[4]  = '{6'b000010, 0, 0, 10'b0101101000, 2'b00};
        tbl[5]  = '{6'b100110, 0, 0, 10'b0101101110, 2'b00};
        tbl[6]  = '{6'b010001, 0, 0, 10'b0101001100, 2'b00};
        tbl[7]  = '{6'b010010, 0, 0, 10'b0101001011, 2'b00};
        tbl[8]  = '{6'b010011, 0, 0, 10'b0101001111, 2'b00};
        tbl[9]  = '{6'b011000, 0, 0, 10'b1001010010, 2'b00};
        tbl[10] = '{6'b110000, 0, 0, 10'b0101100000, 2'b00};
        tbl[11] = '{6'b110001, 0, 0, 10'b0111101000, 2'b00};
        tbl[12] = '{6'b110100, 1, 0, 10'b0001100001, 2'b01};
        tbl[13] = '{6'b110100, 0, 1, 10'b0001100001, 2'b00};
        tbl[14] = '{6'b110101, 0, 0, 10'b0001100001, 2'b01};
        tbl[15] = '{6'b110101, 1, 0, 10'b0001100001, 2'b00};
        tbl[16] = '{6'b110110, 0, 1, 10'b0001100000, 2'b01};
        tbl[17] = '{6'b110110, 1, 0, 10'b0001100000, 2'b00};
        tbl[18] = '{6'b111000, 0, 0, 10'b0001000000, 2'b11};
        tbl[19] = '{6'b111001, 0, 0, 10'b0001000000, 2'b10};
        tbl[20] = '{6'b111010, 0, 0, 10'b0000000000, 2'b11};
        tbl[21] = '{6'b111111, 0, 0, 10'b0001000000, 2'b00};

        // reset state
        rst = 1'b0; opcode = 6'b000000; zero = 0; sign = 0; imem_ready = 1; dmem_ready = 1;
        #12;
        chk("rst_state", state_dbg, 0);
        chk("rst_fcode", fault_code, 0);
        chk("rst_instret", instret, 0);
        chk("rst_strobes", {imem_req, PCWre, IRWre, RegWre, mRD, mWR, halted, fault}, 0);

        for (int i = 0; i < 22; i++) begin
            opcode = tbl[i].op; zero = tbl[i].z; sign = tbl[i].s;
            #1;
            chk($sformatf("sel[%0d]", i), sel_now, tbl[i].sel);
            chk($sformatf("pcsrc[%0d]", i), PCSrc, tbl[i].pc);
        end

        // add: IF, ID, EXE_A, WB_A, back to IF
        do_reset(6'b000000, 1, 1);
        #1;
        chk("add_if", {state_dbg, imem_req, IRWre, RegWre, PCWre}, {4'd0, 4'b1100});
        tick(); #1;
        chk("add_id", {state_dbg, IRWre, RegWre, PCWre}, {4'd1, 3'b000});
        tick(); #1;
        chk("add_exe", {state_dbg, IRWre, RegWre, PCWre}, {4'd6, 3'b000});
        tick(); #1;
        chk("add_wb", {state_dbg, IRWre, RegWre, PCWre}, {4'd7, 3'b011});
        tick(); #1;
        chk("add_done", state_dbg, 0);

        // lw with dmem_ready arriving on the fourth MEM cycle
        do_reset(6'b110001, 1, 0);
        irw_n = 0; mrd_n = 0;
        #1; irw_n += int'(IRWre); tick();
        #1; irw_n += int'(IRWre); tick();
        #1; irw_n += int'(IRWre); chk("lw_exem", state_dbg, 2); tick();
        for (int i = 0; i < 4; i++) begin
            dmem_ready = (i == 3);
            #1;
            chk("lw_mem_state", state_dbg, 3);
            mrd_n += int'(mRD); irw_n += int'(IRWre);
            tick();
        end
        dmem_ready = 0;
        #1;
        chk("lw_mrd_cycles", mrd_n, 4);
        chk("lw_wbl", {state_dbg, RegWre, PCWre, mRD}, {4'd4, 3'b110});
        irw_n += int'(IRWre);
        tick(); #1;
        chk("lw_irw_once", irw_n, 1);
        chk("lw_done", state_dbg, 0);

        // beq taken, and bne not taken, observed in EXE_B
        do_reset(6'b110100, 1, 1);
        zero = 1;
        tick(); tick(); #1;
        chk("beq_taken", {state_dbg, PCSrc, PCWre}, {4'd5, 2'b01, 1'b1});
        tick(); #1;
        chk("beq_back_if", state_dbg, 0);
        opcode = 6'b110101;
        tick(); tick(); #1;
        chk("bne_not_taken", {state_dbg, PCSrc, PCWre}, {4'd5, 2'b00, 1'b1});

        // reset during a held sw: mWR must drop without a clock
        do_reset(6'b110000, 1, 0);
        tick(); tick(); tick(); #1;
        chk("sw_mwr_held", {state_dbg, mWR}, {4'd3, 1'b1});
        rst = 1'b0; #1;
        chk("sw_async_rst", {state_dbg, mWR, PCWre}, {4'd0, 2'b00});
        @(negedge clk);

        // fetch timeout: 15 not-ready IF cycles, request dropped on the 15th
        do_reset(6'b000000, 0, 0);
        req_n = 0;
        for (int i = 0; i < 14; i++) begin
            #1; req_n += int'(imem_req); tick();
        end
        #1;
        chk("tmo_req_cycles", req_n, 14);
        chk("tmo_last_cycle", {state_dbg, imem_req}, {4'd0, 1'b0});
        tick(); #1;
        chk("tmo_fault", {state_dbg, fault, fault_code, imem_req}, {4'd9, 1'b1, 2'b01, 1'b0});
        imem_ready = 1;
        tick(); tick(); #1;
        chk("tmo_absorbing", {state_dbg, imem_req, IRWre}, {4'd9, 2'b00});

        // ready on the 15th cycle wins over the timeout
        do_reset(6'b000000, 0, 0);
        repeat (14) tick();
        imem_ready = 1; #1;
        chk("tmo_ready_wins", {imem_req, IRWre}, 2'b11);
        tick(); #1;
        chk("tmo_no_fault", {state_dbg, fault, fault_code}, {4'd1, 1'b0, 2'b00});

        // illegal opcode
        do_reset(6'b101010, 1, 1);
        tick(); tick(); #1;
        chk("illegal_fault", {state_dbg, fault, fault_code}, {4'd9, 1'b1, 2'b10});

        // halt is absorbing and silent
        do_reset(6'b111111, 1, 1);
        tick(); tick(); #1;
        chk("halt_state", {state_dbg, halted, fault}, {4'd8, 1'b1, 1'b0});
        any_strobe = 0;
        for (int i = 0; i < 20; i++) begin
            tick(); #1;
            any_strobe += int'(imem_req | PCWre | IRWre | RegWre | mRD | mWR);
            if (state_dbg != 4'd8) any_strobe += 100;
        end
        chk("halt_silent", any_strobe, 0);
        rst = 1'b0; #1;
        chk("halt_rst_if", {state_dbg, halted}, {4'd0, 1'b0});
        @(negedge clk);

        // retired count: 3 ALU ops + j + sw
        do_reset(6'b000000, 1, 1);
        run_instr(6'b000000, 4);
        run_instr(6'b000001, 4);
        run_instr(6'b010010, 4);
        run_instr(6'b111000, 2);
        run_instr(6'b110000, 4);
        #1;
`ifdef MC_PERF_CNT_EN
        exp_instret = 32'd5;
`else
        exp_instret = 32'd0;
`endif
        chk("instret", instret, exp_instret);
        chk("perf_end_if", state_dbg, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
